// File: rtl/nios_system_key_pio.sv
// Avalon-MM key/switch PIO: synchronised input pins, per-bit edge capture, masked level irq.
// Latency: pin to edgecapture 2 cycles; read data 1 cycle; irq combinational from registered state.
// Backpressure: none; the slave accepts every access on the cycle it is presented.
module nios_system_key_pio #(
    parameter int WIDTH     = 4,
    parameter int EDGE_TYPE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] prev;
    logic [1:0]       arm_cnt;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] edge_raw;
    logic [WIDTH-1:0] edge_vec;
    logic [WIDTH-1:0] clr;
    logic [31:0]      rd_mux;
    logic             wr_en;
    logic             rd_en;
    logic             armed;

    assign wr_en = chipselect & ~write_n;
    assign rd_en = chipselect & write_n;
    assign armed = (arm_cnt == 2'd3);

    generate
        if (WIDTH < 32) begin : g_unused
            logic unused_wdata;
            assign unused_wdata = ^writedata[31:WIDTH];
        end
    endgenerate

    // prev is zero for the first cycles after reset, so edges stay gated until the pipeline is full
    always_comb begin
        edge_raw = '0;
        case (EDGE_TYPE)
            0:       edge_raw = sync2 & ~prev;
            1:       edge_raw = ~sync2 & prev;
            default: edge_raw = sync2 ^ prev;
        endcase
        edge_vec = armed ? edge_raw : '0;
    end

    always_comb begin
        clr = '0;
        if (wr_en && address == 2'd3) begin
            clr = writedata[WIDTH-1:0];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux[WIDTH-1:0] = sync2;
            2'd2:    rd_mux[WIDTH-1:0] = irqmask;
            2'd3:    rd_mux[WIDTH-1:0] = edgecapture;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1       <= '0;
            sync2       <= '0;
            prev        <= '0;
            arm_cnt     <= '0;
            irqmask     <= '0;
            edgecapture <= '0;
            readdata    <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
            prev  <= sync2;
            if (!armed) begin
                arm_cnt <= arm_cnt + 2'd1;
            end
            if (wr_en && address == 2'd2) begin
                irqmask <= writedata[WIDTH-1:0];
            end
            // a newly detected edge wins over a same-cycle clear
            edgecapture <= (edgecapture & ~clr) | edge_vec;
            if (rd_en) begin
                readdata <= rd_mux;
            end
        end
    end

    assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_nios_system_key_pio.sv
// Bench for nios_system_key_pio: falling-edge and rising-edge instances share one bus,
// checked against a pin-history reference model through a read scoreboard.
module tb_nios_system_key_pio;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata_f;
    logic [31:0] readdata_r;
    logic        irq_f;
    logic        irq_r;

    int checks   = 0;
    int failures = 0;

    nios_system_key_pio #(.WIDTH(4), .EDGE_TYPE(1)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata_f), .irq(irq_f)
    );

    nios_system_key_pio #(.WIDTH(4), .EDGE_TYPE(0)) dut_r (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata_r), .irq(irq_r)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pin samples since reset release, indexed by clock edge number
    typedef struct {
        logic [31:0] f;
        logic [31:0] r;
        logic [1:0]  a;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] smp[$];
    int         m      = 0;
    logic [3:0] mask   = '0;
    logic [3:0] ec_f   = '0;
    logic [3:0] ec_r   = '0;

    function automatic logic [3:0] samp(input int idx);
        if (idx < 1 || idx > smp.size()) return 4'h0;
        return smp[idx-1];
    endfunction

    always @(posedge clk or negedge reset_n) begin : model
        logic [3:0] cur, prv, fall, rise, clr;
        exp_t       e;
        if (!reset_n) begin
            m = 0;
            smp.delete();
            exp_q.delete();
            mask = '0;
            ec_f = '0;
            ec_r = '0;
        end else begin
            m++;
            smp.push_back(in_port);
            // the value visible on the data register before this edge is the pin two edges old
            if (chipselect && write_n) begin
                e.a = address;
                e.f = '0;
                e.r = '0;
                case (address)
                    2'd0: begin e.f[3:0] = samp(m-2); e.r[3:0] = samp(m-2); end
                    2'd2: begin e.f[3:0] = mask;      e.r[3:0] = mask;      end
                    2'd3: begin e.f[3:0] = ec_f;      e.r[3:0] = ec_r;      end
                    default: ;
                endcase
                exp_q.push_back(e);
            end
            fall = '0;
            rise = '0;
            if (m >= 4) begin
                cur  = samp(m-2);
                prv  = samp(m-3);
                fall = ~cur & prv;
                rise = cur & ~prv;
            end
            clr = '0;
            if (chipselect && !write_n) begin
                if (address == 2'd2) mask = writedata[3:0];
                if (address == 2'd3) clr = writedata[3:0];
            end
            ec_f = (ec_f & ~clr) | fall;
            ec_r = (ec_r & ~clr) | rise;
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("rd_fall_a%0d", e.a), readdata_f, e.f);
            check($sformatf("rd_rise_a%0d", e.a), readdata_r, e.r);
        end
        check("irq_fall", {31'b0, irq_f}, {31'b0, |(ec_f & mask)});
        check("irq_rise", {31'b0, irq_r}, {31'b0, |(ec_r & mask)});
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic do_read(input logic [1:0] a);
        chipselect = 1'b1; write_n = 1'b1; address = a;
        @(negedge clk);
        chipselect = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        address = 2'd0; writedata = '0; in_port = 4'hF;
        idle(3);
        check("reset_rd_fall", readdata_f, 32'h0);
        check("reset_rd_rise", readdata_r, 32'h0);
        check("reset_irq", {30'b0, irq_f, irq_r}, 32'h0);
        reset_n = 1'b1;

        // falling edge on bit 2 with mask clear: capture but no irq
        idle(10);
        in_port = 4'hB;
        idle(3);
        do_read(2'd3);
        idle(1);

        // unmask, then read capture while irq stays asserted
        do_write(2'd2, 32'h4);
        do_read(2'd3);
        idle(2);

        // clear landing on the same edge as a new capture: set wins
        in_port = 4'hF;
        idle(4);
        in_port = 4'hB;
        idle(2);
        do_write(2'd3, 32'h4);
        do_read(2'd3);
        idle(2);
        do_write(2'd3, 32'h4);
        do_read(2'd3);
        idle(2);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            int op;
            if ($urandom_range(0, 2) == 0) in_port = 4'($urandom);
            op = int'($urandom_range(0, 9));
            if (op < 4) begin
                do_read(2'($urandom));
            end else if (op < 6) begin
                do_write(2'd2, $urandom);
            end else if (op == 6) begin
                do_write(2'($urandom), $urandom);
            end else begin
                idle(1);
            end
        end
        idle(3);

        // build captures 3 with full mask, then reset asynchronously mid-cycle
        in_port = 4'hF;
        idle(5);
        in_port = 4'hC;
        idle(4);
        do_write(2'd2, 32'hF);
        do_read(2'd3);
        idle(1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_irq_fall", {31'b0, irq_f}, 32'h0);
        check("async_rst_irq_rise", {31'b0, irq_r}, 32'h0);
        check("async_rst_rd_fall", readdata_f, 32'h0);
        check("async_rst_rd_rise", readdata_r, 32'h0);

        // pins high through release: rising instance must not capture
        in_port = 4'hA;
        idle(2);
        reset_n = 1'b1;
        idle(8);
        do_read(2'd3);
        do_read(2'd0);
        do_read(2'd2);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
